rxfifo_param: RTL and testbench
===============================

# rxfifo_param

Parametrised receive FIFO between the SSP receive shift logic and the APB read path. Buffers `DATA_W`-bit frames from the receiver in a `DEPTH`-entry circular buffer, returns them on APB reads, and raises `SSPRXINTR` when occupancy reaches a programmable threshold. It adds over the fixed 4x8 buffer:

- explicit full/empty flags;
- an occupancy count;
- simultaneous push/pop;
- overrun detection.

## Interface
Parameters:
- `DATA_W`, 8, frame width in bits.
- `DEPTH`, 4, number of entries; power of two, at least 2.
- `ADDR_W`, `$clog2(DEPTH)`, pointer width; derived, never overridden.
- `THRESH`, `DEPTH`, occupancy at which `SSPRXINTR` asserts; legal range 1..`DEPTH`.

Ports:
- `PCLK` input 1: sole clock; all state changes on the rising edge.
- `CLEAR` input 1: reset, synchronous, active-high.
- `PSEL` input 1: APB select.
- `PWRITE` input 1: APB direction; read when low.
- `RxData` input `DATA_W`: received frame.
- `rx_ready` input 1: push strobe; one push per high cycle.
- `PRDATA` output `DATA_W`: registered read data.
- `SSPRXINTR` output 1: receive interrupt, level.
- `rx_empty` output 1: FIFO holds zero entries.
- `rx_full` output 1: FIFO holds `DEPTH` entries.
- `rx_count` output `ADDR_W+1`: current occupancy, 0..`DEPTH`.
- `rx_overrun` output 1: sticky; a frame was dropped.

## Operation
- State: `rd_ptr`, `wr_ptr` (`ADDR_W` bits each), `count` (`ADDR_W+1` bits), storage array.
- Pointers wrap modulo `DEPTH` by natural overflow.
- `rx_empty` = (`count`==0). `rx_full` = (`count`==`DEPTH`). `rx_count` = `count`.
- Pop request: `rd_req` = `PSEL` & ~`PWRITE`.
- Pop accept: `pop` = `rd_req` & ~`rx_empty`.
- Push accept: `push` = `rx_ready` & (~`rx_full` | `pop`). A full FIFO accepts a push only if a pop occurs in the same cycle.
- On `push`: `mem[wr_ptr]` <= `RxData`; `wr_ptr` increments.
- On `pop`: `PRDATA` <= `mem[rd_ptr]`; `rd_ptr` increments.
- Count update:
  - `push` only: `count`+1.
  - `pop` only: `count`-1.
  - both or neither: unchanged.
- Empty with `rd_req`: no pop, no bypass of a same-cycle push; `PRDATA` holds its previous value; pointers unchanged.
- Full with `rx_ready` and no pop: frame dropped; storage and pointers unchanged; overrun event (see Configuration).
- `SSPRXINTR` = (`count` >= `THRESH`), taken from the registered count. It falls once pops bring occupancy below `THRESH`. There is no other clear mechanism.
- Consecutive identical frames are stored as distinct entries; no data-value filtering.
- `CLEAR` has priority over every other input in the same cycle.

## Timing
- Reset values: `PRDATA`=0, `SSPRXINTR`=0, `rx_empty`=1, `rx_full`=0, `rx_count`=0, `rx_overrun`=0, both pointers 0. Storage contents after reset are don't-care.
- `CLEAR` asserted mid-operation discards all entries at that edge. A push or pop in the same cycle is ignored.
- Push-to-visible latency: a frame pushed at edge N is poppable by a read presented in cycle N+1. `rx_count`, `rx_empty`, `rx_full` and `SSPRXINTR` reflect it after edge N.
- Read latency: a read accepted at edge N drives `PRDATA` from edge N onward. It is stable for the whole cycle after the read and holds until the next accepted pop.
- Back-to-back reads pop one entry per cycle while `PSEL` & ~`PWRITE` stays high.
- Sustained throughput: one push and one pop per cycle in any occupancy state except empty (pop blocked) and full-without-pop (push blocked).

## Configuration
- Macro: `RXFIFO_OVERRUN_EN`.
- Defined:
  - `rx_overrun` sets at the edge where `rx_ready` & `rx_full` & ~`pop`.
  - It stays set until `CLEAR`, or an APB write cycle (`PSEL` & `PWRITE`) clears it at the following edge.
  - Set has priority over the write-clear in the same cycle.
- Undefined: `rx_overrun` is tied to 0 and no overrun logic is synthesised. Dropping on full is unchanged.

## Test plan
- Reset then fill (`DEPTH`=4, `THRESH`=4): push 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles.
  - Required: `rx_count` steps 1..4; `rx_full`=1 and `SSPRXINTR`=1 after the 4th edge; `rx_empty`=0.
- Drain in order: four back-to-back reads from full.
  - Required: `PRDATA` = 0xA1, 0xA2, 0xA3, 0xA4 on successive cycles; then `rx_empty`=1, `SSPRXINTR`=0.
  - A 5th read leaves `PRDATA`=0xA4.
- Overrun (macro defined): full FIFO, push 0x55 with no read.
  - Required: 0x55 dropped; `rx_overrun`=1 next cycle; subsequent reads return the original 4 entries.
  - One `PSEL`=1, `PWRITE`=1 cycle clears `rx_overrun`.
- Simultaneous push/pop:
  - At `count`=2: push 0x77 with a read. Required: `count` stays 2; `PRDATA` = oldest entry.
  - At full: push plus read. Required: push accepted, no overrun.
  - At empty: push plus read. Required: `PRDATA` unchanged, `count`=1.
- Wrap-around and `THRESH`=2, `DEPTH`=8: 20 push/pop pairs interleaved at occupancy 1..3.
  - Required: FIFO order preserved across pointer wrap; `SSPRXINTR` high exactly when `count` >= 2.
- Mid-operation reset: `CLEAR` at `count`=3 with a concurrent push and read.
  - Required: next cycle `count`=0, `rx_empty`=1, `PRDATA`=0, `SSPRXINTR`=0.

Source files
------------

// File: rtl/rxfifo_param_if.sv
// rtl/rxfifo_param_if.sv - APB read / receive push bundle for rxfifo_param
interface rxfifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              PSEL;
    logic              PWRITE;
    logic [DATA_W-1:0] RxData;
    logic              rx_ready;
    logic [DATA_W-1:0] PRDATA;
    logic              SSPRXINTR;
    logic              rx_empty;
    logic              rx_full;
    logic [ADDR_W:0]   rx_count;
    logic              rx_overrun;

    modport master (
        output PSEL, PWRITE, RxData, rx_ready,
        input  PRDATA, SSPRXINTR, rx_empty, rx_full, rx_count, rx_overrun
    );

    modport slave (
        input  PSEL, PWRITE, RxData, rx_ready,
        output PRDATA, SSPRXINTR, rx_empty, rx_full, rx_count, rx_overrun
    );
endinterface

// File: rtl/rxfifo_param.sv
// rtl/rxfifo_param.sv - parametrised SSP receive FIFO; RXFIFO_OVERRUN_EN enables sticky overrun flag
module rxfifo_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int THRESH = DEPTH
) (
    input  logic PCLK,
    input  logic CLEAR,
    rxfifo_param_if.slave bus
);
    localparam logic [ADDR_W:0] FULL_CNT   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] THRESH_CNT = (ADDR_W+1)'(THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] prdata_q;

    logic rd_req;
    logic empty;
    logic full;
    logic pop;
    logic push;

    // Handshake decode; a full FIFO still takes a frame when a pop frees a slot this cycle
    always_comb begin
        rd_req = bus.PSEL & ~bus.PWRITE;
        empty  = (count == '0);
        full   = (count == FULL_CNT);
        pop    = rd_req & ~empty;
        push   = bus.rx_ready & (~full | pop);
    end

    // Storage write; contents are not reset, and a push coinciding with CLEAR is discarded
    always_ff @(posedge PCLK) begin
        if (!CLEAR && push) begin
            mem[wr_ptr] <= bus.RxData;
        end
    end

    // Pointers, occupancy and registered read data
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            prdata_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + ADDR_W'(1);
                prdata_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef RXFIFO_OVERRUN_EN
    logic overrun_q;

    // Sticky drop flag: a dropped frame outranks the APB write-clear in the same cycle
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            overrun_q <= 1'b0;
        end else if (bus.rx_ready & full & ~pop) begin
            overrun_q <= 1'b1;
        end else if (bus.PSEL & bus.PWRITE) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.rx_overrun = overrun_q;
`else
    assign bus.rx_overrun = 1'b0;
`endif

    assign bus.PRDATA    = prdata_q;
    assign bus.rx_count  = count;
    assign bus.rx_empty  = empty;
    assign bus.rx_full   = full;
    assign bus.SSPRXINTR = (count >= THRESH_CNT);

endmodule

// File: tb/tb_rxfifo_param.sv
// tb/tb_rxfifo_param.sv - directed bench for rxfifo_param (4x8 thresh 4, and 8x8 thresh 2)
module tb_rxfifo_param;
    logic clk;
    logic clear;
    int   checks;
    int   errors;

    rxfifo_param_if #(.DATA_W(8), .ADDR_W(2)) if_a ();
    rxfifo_param_if #(.DATA_W(8), .ADDR_W(3)) if_b ();

    rxfifo_param #(.DATA_W(8), .DEPTH(4), .THRESH(4)) dut_a (
        .PCLK  (clk),
        .CLEAR (clear),
        .bus   (if_a)
    );

    rxfifo_param #(.DATA_W(8), .DEPTH(8), .THRESH(2)) dut_b (
        .PCLK  (clk),
        .CLEAR (clear),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        if_a.PSEL = 1'b0; if_a.PWRITE = 1'b0; if_a.rx_ready = 1'b0; if_a.RxData = 8'h00;
    endtask

    task automatic idle_b();
        if_b.PSEL = 1'b0; if_b.PWRITE = 1'b0; if_b.rx_ready = 1'b0; if_b.RxData = 8'h00;
    endtask

    logic [7:0] model_q [$];
    logic [7:0] exp_rd;
    logic [7:0] next_b;
    int         mode;
    bit         ovr_en;

    initial begin
        checks = 0;
        errors = 0;
`ifdef RXFIFO_OVERRUN_EN
        ovr_en = 1'b1;
`else
        ovr_en = 1'b0;
`endif
        idle_a();
        idle_b();
        clear = 1'b1;
        tick();
        clear = 1'b0;

        check("reset_prdata",  if_a.PRDATA,     8'h00);
        check("reset_intr",    if_a.SSPRXINTR,  1'b0);
        check("reset_empty",   if_a.rx_empty,   1'b1);
        check("reset_full",    if_a.rx_full,    1'b0);
        check("reset_count",   if_a.rx_count,   3'd0);
        check("reset_overrun", if_a.rx_overrun, 1'b0);

        // Fill A1..A4
        for (int i = 0; i < 4; i++) begin
            if_a.rx_ready = 1'b1;
            if_a.RxData   = 8'hA1 + 8'(i);
            tick();
            check($sformatf("fill_count_%0d", i), if_a.rx_count, 32'(i + 1));
            if (i == 2) check("fill_intr_below_thresh", if_a.SSPRXINTR, 1'b0);
        end
        idle_a();
        check("fill_full",  if_a.rx_full,   1'b1);
        check("fill_intr",  if_a.SSPRXINTR, 1'b1);
        check("fill_empty", if_a.rx_empty,  1'b0);

        // Push into full FIFO with no read: frame dropped
        if_a.rx_ready = 1'b1;
        if_a.RxData   = 8'h55;
        tick();
        idle_a();
        check("drop_count",   if_a.rx_count,   3'd4);
        check("drop_overrun", if_a.rx_overrun, ovr_en);
        tick();
        check("overrun_sticky", if_a.rx_overrun, ovr_en);
        if_a.PSEL = 1'b1; if_a.PWRITE = 1'b1;
        tick();
        idle_a();
        check("overrun_wclear", if_a.rx_overrun, 1'b0);
        check("wclear_count",   if_a.rx_count,   3'd4);

        // Drain in order with back-to-back reads
        if_a.PSEL = 1'b1; if_a.PWRITE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("drain_data_%0d", i),  if_a.PRDATA,   8'hA1 + 8'(i));
            check($sformatf("drain_count_%0d", i), if_a.rx_count, 32'(3 - i));
            if (i == 0) check("drain_intr_fall", if_a.SSPRXINTR, 1'b0);
        end
        check("drain_empty", if_a.rx_empty,  1'b1);
        check("drain_intr",  if_a.SSPRXINTR, 1'b0);
        tick();
        check("extra_read_hold",  if_a.PRDATA,   8'hA4);
        check("extra_read_count", if_a.rx_count, 3'd0);

        // Empty: push plus read, no bypass
        if_a.rx_ready = 1'b1; if_a.RxData = 8'h10;
        tick();
        idle_a();
        check("empty_pp_prdata", if_a.PRDATA,   8'hA4);
        check("empty_pp_count",  if_a.rx_count, 3'd1);
        if_a.rx_ready = 1'b1; if_a.RxData = 8'h11;
        tick();
        check("push_11_count", if_a.rx_count, 3'd2);

        // Count 2: push plus read keeps occupancy
        if_a.RxData = 8'h77; if_a.PSEL = 1'b1;
        tick();
        if_a.PSEL = 1'b0;
        check("mid_pp_prdata", if_a.PRDATA,   8'h10);
        check("mid_pp_count",  if_a.rx_count, 3'd2);
        if_a.RxData = 8'h12;
        tick();
        if_a.RxData = 8'h13;
        tick();
        check("refill_full", if_a.rx_full, 1'b1);

        // Full: push plus read is accepted, no overrun
        if_a.RxData = 8'h14; if_a.PSEL = 1'b1;
        tick();
        idle_a();
        check("full_pp_prdata",  if_a.PRDATA,     8'h11);
        check("full_pp_count",   if_a.rx_count,   3'd4);
        check("full_pp_overrun", if_a.rx_overrun, 1'b0);
        if_a.PSEL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            case (i)
                0: exp_rd = 8'h77;
                1: exp_rd = 8'h12;
                2: exp_rd = 8'h13;
                default: exp_rd = 8'h14;
            endcase
            check($sformatf("full_pp_drain_%0d", i), if_a.PRDATA, exp_rd);
        end
        idle_a();
        check("full_pp_drain_empty", if_a.rx_empty, 1'b1);

        // Mid-operation CLEAR at count 3 with concurrent push and read
        for (int i = 0; i < 3; i++) begin
            if_a.rx_ready = 1'b1; if_a.RxData = 8'h21 + 8'(i);
            tick();
        end
        check("pre_clear_count", if_a.rx_count, 3'd3);
        if_a.RxData = 8'h24; if_a.PSEL = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
        idle_a();
        check("clear_count",  if_a.rx_count,  3'd0);
        check("clear_empty",  if_a.rx_empty,  1'b1);
        check("clear_prdata", if_a.PRDATA,    8'h00);
        check("clear_intr",   if_a.SSPRXINTR, 1'b0);
        if_a.rx_ready = 1'b1; if_a.RxData = 8'h30;
        tick();
        idle_a();
        if_a.PSEL = 1'b1;
        tick();
        idle_a();
        check("post_clear_data", if_a.PRDATA, 8'h30);

        // DEPTH 8, THRESH 2: interleaved traffic across pointer wrap
        next_b = 8'h40;
        if_b.rx_ready = 1'b1; if_b.RxData = next_b;
        model_q.push_back(next_b);
        next_b++;
        tick();
        idle_b();
        check("b_first_count", if_b.rx_count, 4'd1);
        check("b_first_intr",  if_b.SSPRXINTR, 1'b0);
        for (int i = 0; i < 20; i++) begin
            mode = i % 6;
            idle_b();
            exp_rd = if_b.PRDATA;
            if (mode == 3 || mode == 4 || mode == 2 || mode == 5) begin
                if_b.PSEL = 1'b1;
                exp_rd = model_q.pop_front();
            end
            if (mode == 0 || mode == 1 || mode == 2 || mode == 5) begin
                if_b.rx_ready = 1'b1;
                if_b.RxData   = next_b;
                model_q.push_back(next_b);
                next_b++;
            end
            tick();
            check($sformatf("b_data_%0d", i),  if_b.PRDATA,    exp_rd);
            check($sformatf("b_count_%0d", i), if_b.rx_count,  32'(model_q.size()));
            check($sformatf("b_intr_%0d", i),  if_b.SSPRXINTR, 32'(model_q.size() >= 2));
        end
        idle_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
